native_pixel_packer: RTL and testbench

Write-path stage directly downstream of the native input port. It consumes the port's aligned pixel stream and frame markers (frame start, line end, frame end) and packs PACK consecutive pixels into one wide word. It tags each word with first/last/keep sideband, buffers the words in a small FIFO, and presents them to the VDMA write-burst logic over a valid/ready handshake. The input side has no backpressure: words that find the FIFO full are dropped and flagged.

---
 rtl/native_pixel_packer.sv | 159 +++++++++++++++
 tb/tb_native_pixel_packer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/native_pixel_packer.sv
// Packs PACK aligned pixels into one wide word with first/last/keep sideband and
// queues the words in a small FIFO towards the VDMA write-burst logic.
module native_pixel_packer #(
    parameter int DSIZE = 24,
    parameter int PACK  = 4,
    parameter     MODE  = "ONCE",
    parameter int DEPTH = 4
) (
    input  logic                  clock_i,
    input  logic                  rst_i,
    input  logic                  falign_i,
    input  logic                  lalign_i,
    input  logic                  ealign_i,
    input  logic                  idata_vld_i,
    input  logic [DSIZE-1:0]      idata_i,
    output logic                  odata_vld_o,
    input  logic                  odata_rdy_i,
    output logic [DSIZE*PACK-1:0] odata_o,
    output logic [PACK-1:0]       okeep_o,
    output logic                  ofirst_o,
    output logic                  olast_o,
    output logic                  overflow_o
);

    localparam int  WW        = DSIZE * PACK;
    localparam int  SW        = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int  AW        = $clog2(DEPTH);
    localparam int  PW        = AW + 1;
    localparam int  FW        = AW + 2;
    localparam int  EW        = WW + PACK + 2;
    localparam bit  LINE_MODE = (MODE == "LINE");

    logic [SW-1:0]  slot_q, slot_d;
    logic [WW-1:0]  acc_q, acc_d;
    logic           pend_vld_q, pend_vld_d;
    logic [WW-1:0]  pend_q, pend_d;
    logic           first_q, first_d;
    logic           ovf_q, ovf_d;
    logic [PW-1:0]  wptr_q, wptr_d;
    logic [PW-1:0]  rptr_q, rptr_d;
    logic [EW-1:0]  mem_q [DEPTH];

    logic           flush;
    logic           push0, push1;
    logic [WW-1:0]  data1;
    logic [PACK-1:0] keep1;
    logic           first0, first1;
    logic [PW-1:0]  count;
    logic           empty, pop;
    logic [FW-1:0]  free;
    logic           acc0, acc1, drop;
    logic [PW-1:0]  widx1;
    logic [EW-1:0]  entry0, entry1, head;

    assign flush = ealign_i | falign_i | (LINE_MODE & lalign_i);

    // Up to two words can leave the packer in one cycle: the pending word pushed
    // out by a new pixel, and the flush word that then covers that pixel.
    always_comb begin
        acc_d      = acc_q;
        slot_d     = slot_q;
        pend_vld_d = pend_vld_q;
        pend_d     = pend_q;
        push0      = 1'b0;
        push1      = 1'b0;
        data1      = '0;
        keep1      = '0;
        if (idata_vld_i) begin
            for (int i = 0; i < PACK; i++) begin
                if (slot_q == SW'(i)) acc_d[i*DSIZE +: DSIZE] = idata_i;
            end
            push0 = pend_vld_q;
            if (slot_q == SW'(PACK-1)) begin
                pend_vld_d = 1'b1;
                pend_d     = acc_d;
                slot_d     = '0;
            end else begin
                pend_vld_d = 1'b0;
                slot_d     = slot_q + SW'(1);
            end
        end
        if (flush) begin
            if (pend_vld_d) begin
                push1      = 1'b1;
                data1      = pend_d;
                keep1      = '1;
                pend_vld_d = 1'b0;
            end else if (slot_d != '0) begin
                push1 = 1'b1;
                for (int i = 0; i < PACK; i++) begin
                    if (SW'(i) < slot_d) begin
                        data1[i*DSIZE +: DSIZE] = acc_d[i*DSIZE +: DSIZE];
                        keep1[i]                = 1'b1;
                    end
                end
                slot_d = '0;
            end
        end
    end

    // A dropped word still consumes the first flag, as if it had been queued.
    always_comb begin
        first0  = first_q;
        first1  = first_q & ~push0;
        first_d = falign_i ? 1'b1 : (first_q & ~(push0 | push1));
        entry0  = {first0, 1'b0, {PACK{1'b1}}, pend_q};
        entry1  = {first1, 1'b1, keep1, data1};
    end

    always_comb begin
        count  = wptr_q - rptr_q;
        empty  = (count == '0);
        pop    = ~empty & odata_rdy_i;
        free   = FW'(DEPTH) - FW'(count) + FW'(pop);
        acc0   = push0 & (free != '0);
        acc1   = push1 & (free > (acc0 ? FW'(1) : FW'(0)));
        drop   = (push0 & ~acc0) | (push1 & ~acc1);
        ovf_d  = drop | (ovf_q & ~falign_i);
        widx1  = acc0 ? wptr_q + PW'(1) : wptr_q;
        wptr_d = wptr_q + PW'(acc0) + PW'(acc1);
        rptr_d = rptr_q + PW'(pop);
    end

    always_ff @(posedge clock_i) begin
        if (rst_i) begin
            slot_q     <= '0;
            acc_q      <= '0;
            pend_vld_q <= 1'b0;
            pend_q     <= '0;
            first_q    <= 1'b0;
            ovf_q      <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            slot_q     <= slot_d;
            acc_q      <= acc_d;
            pend_vld_q <= pend_vld_d;
            pend_q     <= pend_d;
            first_q    <= first_d;
            ovf_q      <= ovf_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!rst_i) begin
            if (acc0) mem_q[wptr_q[AW-1:0]] <= entry0;
            if (acc1) mem_q[widx1[AW-1:0]]  <= entry1;
        end
    end

    // Head fields read as zero while the FIFO is empty, so storage needs no reset.
    assign head        = mem_q[rptr_q[AW-1:0]];
    assign odata_vld_o = ~empty;
    assign {ofirst_o, olast_o, okeep_o, odata_o} = empty ? '0 : head;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_native_pixel_packer.sv
// Bench for native_pixel_packer: a LINE-mode and a ONCE-mode instance share stimulus
// and are compared every cycle against a pixel-queue reference model.
module tb_native_pixel_packer;

    localparam int DSIZE = 24;
    localparam int PACK  = 4;
    localparam int DEPTH = 4;
    localparam int EW    = DSIZE * PACK + PACK + 2;

    logic clock = 1'b0;
    logic rst = 1'b1, falign = 1'b0, lalign = 1'b0, ealign = 1'b0, idata_vld = 1'b0;
    logic [DSIZE-1:0] idata = '0;
    logic odata_rdy = 1'b0;

    logic                  vld [2];
    logic [DSIZE*PACK-1:0] data [2];
    logic [PACK-1:0]       keep [2];
    logic                  first [2], last [2], ovf [2];
    logic [EW+1:0]         obs [2];

    int n_cmp = 0;
    int n_err = 0;

    logic [DSIZE-1:0] pix [2][$];
    logic [EW-1:0]    fq  [2][$];
    bit               mfirst [2];
    bit               movf [2];

    always #5 clock = ~clock;

    native_pixel_packer #(.DSIZE(DSIZE), .PACK(PACK), .MODE("LINE"), .DEPTH(DEPTH)) dut_line (
        .clock_i(clock), .rst_i(rst), .falign_i(falign), .lalign_i(lalign), .ealign_i(ealign),
        .idata_vld_i(idata_vld), .idata_i(idata), .odata_vld_o(vld[0]), .odata_rdy_i(odata_rdy),
        .odata_o(data[0]), .okeep_o(keep[0]), .ofirst_o(first[0]), .olast_o(last[0]),
        .overflow_o(ovf[0]));

    native_pixel_packer #(.DSIZE(DSIZE), .PACK(PACK), .MODE("ONCE"), .DEPTH(DEPTH)) dut_once (
        .clock_i(clock), .rst_i(rst), .falign_i(falign), .lalign_i(lalign), .ealign_i(ealign),
        .idata_vld_i(idata_vld), .idata_i(idata), .odata_vld_o(vld[1]), .odata_rdy_i(odata_rdy),
        .odata_o(data[1]), .okeep_o(keep[1]), .ofirst_o(first[1]), .olast_o(last[1]),
        .overflow_o(ovf[1]));

    assign obs[0] = {vld[0], first[0], last[0], keep[0], data[0], ovf[0]};
    assign obs[1] = {vld[1], first[1], last[1], keep[1], data[1], ovf[1]};

    // Reference: pixels queue up until a full word is followed by another pixel
    // (word released, olast=0) or a flush drains whatever is queued (olast=1).
    task automatic take_word(input int m, input int n, input bit is_last, output logic [EW-1:0] w);
        logic [DSIZE*PACK-1:0] d = '0;
        logic [PACK-1:0]       k = '0;
        for (int i = 0; i < n; i++) begin
            d[i*DSIZE +: DSIZE] = pix[m].pop_front();
            k[i] = 1'b1;
        end
        w = {mfirst[m], is_last, k, d};
        mfirst[m] = 1'b0;
    endtask

    task automatic model_step(input int m, input bit f, input bit l, input bit e, input bit v,
                              input logic [DSIZE-1:0] d, input bit r, input bit rs);
        logic [EW-1:0] words [$];
        logic [EW-1:0] w;
        bit drop = 1'b0;
        if (rs) begin
            pix[m].delete();
            fq[m].delete();
            mfirst[m] = 1'b0;
            movf[m]   = 1'b0;
            return;
        end
        if (v) begin
            pix[m].push_back(d);
            if (pix[m].size() == PACK + 1) begin
                take_word(m, PACK, 1'b0, w);
                words.push_back(w);
            end
        end
        if ((e || f || (l && m == 0)) && pix[m].size() > 0) begin
            take_word(m, pix[m].size(), 1'b1, w);
            words.push_back(w);
        end
        if (r && fq[m].size() > 0) void'(fq[m].pop_front());
        foreach (words[i]) begin
            if (fq[m].size() < DEPTH) fq[m].push_back(words[i]);
            else drop = 1'b1;
        end
        movf[m] = (f ? 1'b0 : movf[m]) | drop;
        if (f) mfirst[m] = 1'b1;
    endtask

    function automatic logic [EW+1:0] exp_vec(input int m);
        if (fq[m].size() == 0) return {1'b0, {EW{1'b0}}, movf[m]};
        return {1'b1, fq[m][0], movf[m]};
    endfunction

    task automatic cyc(input bit f, input bit l, input bit e, input bit v,
                       input logic [DSIZE-1:0] d, input bit r, input bit rs);
        @(negedge clock);
        falign = f; lalign = l; ealign = e; idata_vld = v; idata = d; odata_rdy = r; rst = rs;
        @(posedge clock);
        model_step(0, f, l, e, v, d, r, rs);
        model_step(1, f, l, e, v, d, r, rs);
        #1;
    endtask

    task automatic test_reset();
        cyc(0, 0, 0, 0, '0, 0, 1);
        cyc(0, 0, 0, 0, '0, 0, 1);
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (obs[m] !== '0) begin
                n_err++;
                $display("FAIL reset[%0d]: got %h exp 0", m, obs[m]);
            end
        end
    endtask

    task automatic test_line_flush();
        logic [EW:0] want;
        cyc(1, 0, 0, 0, '0, 1, 0);
        for (int p = 1; p <= 9; p++) begin
            if (p <= 8) cyc(0, 0, 0, 1, DSIZE'(p), 1, 0);
            else        cyc(0, 1, 0, 0, '0, 1, 0);
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (obs[m] !== exp_vec(m)) begin
                    n_err++;
                    $display("FAIL line_flush[%0d] p%0d: got %h exp %h", m, p, obs[m], exp_vec(m));
                end
            end
            if (p == 5 || p == 9) begin
                want = (p == 5) ? {1'b1, 1'b1, 1'b0, 4'hf, 24'd4, 24'd3, 24'd2, 24'd1}
                                : {1'b1, 1'b0, 1'b1, 4'hf, 24'd8, 24'd7, 24'd6, 24'd5};
                n_cmp++;
                if (obs[0][EW+1:1] !== want) begin
                    n_err++;
                    $display("FAIL line_word p%0d: got %h exp %h", p, obs[0][EW+1:1], want);
                end
            end
        end
    endtask

    task automatic test_partial();
        logic [EW:0] want = {1'b1, 1'b0, 1'b1, 4'b0011, 48'd0, 24'd6, 24'd5};
        for (int p = 1; p <= 7; p++) begin
            if (p <= 6) cyc(0, 0, 0, 1, DSIZE'(p), 1, 0);
            else        cyc(0, 1, 0, 0, '0, 1, 0);
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (obs[m] !== exp_vec(m)) begin
                    n_err++;
                    $display("FAIL partial[%0d] p%0d: got %h exp %h", m, p, obs[m], exp_vec(m));
                end
            end
        end
        n_cmp++;
        if (obs[0][EW+1:1] !== want) begin
            n_err++;
            $display("FAIL partial_word: got %h exp %h", obs[0][EW+1:1], want);
        end
    endtask

    task automatic test_once();
        int words = 0;
        logic [2:0] lasts = '0;
        cyc(1, 0, 0, 0, '0, 1, 0);
        for (int t = 0; t < 17; t++) begin
            if (t < 6)        cyc(0, 0, 0, 1, DSIZE'(t + 1), 1, 0);
            else if (t == 6)  cyc(0, 1, 0, 0, '0, 1, 0);
            else if (t < 13)  cyc(0, 0, 0, 1, DSIZE'(t), 1, 0);
            else if (t == 13) cyc(0, 0, 1, 0, '0, 1, 0);
            else              cyc(0, 0, 0, 0, '0, 1, 0);
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (obs[m] !== exp_vec(m)) begin
                    n_err++;
                    $display("FAIL once[%0d] t%0d: got %h exp %h", m, t, obs[m], exp_vec(m));
                end
            end
            if (vld[1] === 1'b1) begin
                if (words < 3) lasts[words] = last[1];
                words++;
            end
        end
        n_cmp++;
        if (words != 3 || lasts !== 3'b100) begin
            n_err++;
            $display("FAIL once_words: got %0d words lasts %b exp 3 words lasts 100", words, lasts);
        end
    endtask

    task automatic test_overflow();
        cyc(0, 0, 0, 0, '0, 1, 0);
        cyc(1, 0, 0, 0, '0, 0, 0);
        for (int t = 0; t < 30; t++) begin
            if (t < 24)      cyc(0, 0, 0, 1, DSIZE'($urandom), 0, 0);
            else if (t < 28) cyc(0, 0, 0, 0, '0, 1, 0);
            else if (t == 28) cyc(1, 0, 0, 0, '0, 1, 0);
            else             cyc(0, 0, 0, 0, '0, 1, 0);
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (obs[m] !== exp_vec(m)) begin
                    n_err++;
                    $display("FAIL overflow[%0d] t%0d: got %h exp %h", m, t, obs[m], exp_vec(m));
                end
            end
            if (t == 23) begin
                n_cmp++;
                if ({vld[0], first[0], ovf[0]} !== 3'b111) begin
                    n_err++;
                    $display("FAIL ovf_set: got vld/first/ovf %b exp 111", {vld[0], first[0], ovf[0]});
                end
            end
            if (t == 27) begin
                n_cmp++;
                if (vld[0] !== 1'b0) begin
                    n_err++;
                    $display("FAIL ovf_drain: got vld %b exp 0", vld[0]);
                end
            end
            if (t == 28) begin
                n_cmp++;
                if ({vld[0], first[0], last[0], keep[0], ovf[0]} !== 8'b1_0_1_1111_0) begin
                    n_err++;
                    $display("FAIL ovf_clear: got %b exp 10111110",
                             {vld[0], first[0], last[0], keep[0], ovf[0]});
                end
            end
        end
    endtask

    task automatic test_full_push();
        int seen = 0;
        for (int t = 0; t < 26; t++) begin
            if (t < 20)       cyc(0, 0, 0, 1, DSIZE'(100 + t), 0, 0);
            else if (t == 20) cyc(0, 0, 0, 1, DSIZE'(200), 1, 0);
            else              cyc(0, 0, 0, 0, '0, 1, 0);
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (obs[m] !== exp_vec(m)) begin
                    n_err++;
                    $display("FAIL full_push[%0d] t%0d: got %h exp %h", m, t, obs[m], exp_vec(m));
                end
            end
            if (t == 20) begin
                n_cmp++;
                if (ovf[0] !== 1'b0) begin
                    n_err++;
                    $display("FAIL full_push_ovf: got %b exp 0", ovf[0]);
                end
            end
            if (t >= 20 && vld[0] === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 4) begin
            n_err++;
            $display("FAIL full_push_occ: got %0d words exp 4", seen);
        end
    endtask

    task automatic test_mid_reset();
        int words = 0, firsts = 0;
        cyc(1, 0, 0, 0, '0, 1, 0);
        for (int p = 0; p < 3; p++) cyc(0, 0, 0, 1, DSIZE'($urandom), 1, 0);
        cyc(0, 0, 0, 0, '0, 1, 1);
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (obs[m] !== '0) begin
                n_err++;
                $display("FAIL mid_reset[%0d]: got %h exp 0", m, obs[m]);
            end
        end
        for (int t = 0; t < 12; t++) begin
            if (t < 8)       cyc(0, 0, 0, 1, DSIZE'($urandom), 1, 0);
            else if (t == 8) cyc(0, 0, 1, 0, '0, 1, 0);
            else             cyc(0, 0, 0, 0, '0, 1, 0);
            n_cmp++;
            if (obs[0] !== exp_vec(0)) begin
                n_err++;
                $display("FAIL after_reset t%0d: got %h exp %h", t, obs[0], exp_vec(0));
            end
            if (vld[0] === 1'b1) begin
                words++;
                if (first[0] !== 1'b0) firsts++;
            end
        end
        n_cmp++;
        if (words != 2 || firsts != 0) begin
            n_err++;
            $display("FAIL after_reset_first: got %0d words %0d first exp 2 words 0 first", words, firsts);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 600; t++) begin
            cyc($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 3,
                $urandom_range(0, 99) < 75, DSIZE'($urandom), $urandom_range(0, 99) < 60,
                $urandom_range(0, 299) == 0);
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (obs[m] !== exp_vec(m)) begin
                    n_err++;
                    $display("FAIL random[%0d] t%0d: got %h exp %h", m, t, obs[m], exp_vec(m));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_line_flush();
        test_partial();
        test_once();
        test_overflow();
        test_full_push();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
